reg_scoreboard: RTL

//  Tracks in-flight destination registers of long-latency producers (loads, mul/div) from issue to writeback.

---
 rtl/reg_scoreboard_pkg.sv | 19 +
 rtl/reg_scoreboard.sv | 124 ++++++++++++
 2 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the long-latency register scoreboard.
// Holds the stall reason encoding and the register address width.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_RAW  = 2'd1,
    STALL_WAW  = 2'd2,
    STALL_FULL = 2'd3
  } stall_reason_e;

  // x0 is hardwired to zero, so it can never be a real producer or consumer.
  function automatic logic is_tracked(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Scoreboard of in-flight long-latency destination registers (load/mul/div).
// Stalls ID on RAW/WAW hazards against pending writes and when the budget is full.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ID_valid_i,
  input  logic [REG_ADDR_W-1:0]                  ID_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]                  ID_rs2_addr_i,
  input  logic                                   ID_rs1_used_i,
  input  logic                                   ID_rs2_used_i,
  input  logic [REG_ADDR_W-1:0]                  ID_rd_addr_i,
  input  logic                                   ID_RegWrite_i,
  input  logic                                   ID_long_lat_i,
  input  logic                                   flush_i,
  input  logic                                   WB_valid_i,
  input  logic [REG_ADDR_W-1:0]                  WB_rd_addr_i,
  output logic                                   stall_o,
  output logic [1:0]                             stall_reason_o,
  output logic                                   issue_o,
  output logic [NUM_REGS-1:0]                    pending_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic [CNT_W-1:0]                       stall_cnt_o,
  output logic                                   err_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask, eff;
  logic [OUT_W-1:0]    out_q, out_d, count_after_clear;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                clr_hit, raw, waw, full, stall, issue, long_write;
  stall_reason_e       reason;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // A writeback landing this cycle is forwarded, so its register no longer blocks ID.
  always_comb begin
    clr_hit           = 1'b0;
    clr_mask          = '0;
    set_mask          = '0;
    eff               = pending_q;
    count_after_clear = out_q;
    raw               = 1'b0;
    waw               = 1'b0;
    full              = 1'b0;
    stall             = 1'b0;
    issue             = 1'b0;
    long_write        = 1'b0;
    reason            = STALL_NONE;
    pending_d         = pending_q;
    out_d             = out_q;
    cnt_d             = cnt_q;
    err_d             = err_q;

    clr_hit           = WB_valid_i && is_tracked(WB_rd_addr_i) && pending_q[WB_rd_addr_i];
    clr_mask          = clr_hit ? onehot(WB_rd_addr_i) : '0;
    eff               = pending_q & ~clr_mask;
    count_after_clear = out_q - OUT_W'(clr_hit);

    long_write = ID_valid_i && ID_RegWrite_i && ID_long_lat_i && is_tracked(ID_rd_addr_i);

    raw  = ID_valid_i &&
           ((ID_rs1_used_i && is_tracked(ID_rs1_addr_i) && eff[ID_rs1_addr_i]) ||
            (ID_rs2_used_i && is_tracked(ID_rs2_addr_i) && eff[ID_rs2_addr_i]));
    waw  = ID_valid_i && ID_RegWrite_i && is_tracked(ID_rd_addr_i) && eff[ID_rd_addr_i];
    full = long_write && (count_after_clear == OUT_W'(MAX_OUTSTANDING));

    stall = (raw || waw || full) && !flush_i;
    issue = long_write && !stall && !flush_i;

    if (stall) begin
      if (raw)      reason = STALL_RAW;
      else if (waw) reason = STALL_WAW;
      else          reason = STALL_FULL;
    end

    set_mask  = issue ? onehot(ID_rd_addr_i) : '0;
    pending_d = eff | set_mask;

    // Issue and clear in the same cycle cancel out in the count.
    case ({issue, clr_hit})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase

    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    if (WB_valid_i && !clr_hit) err_d = 1'b1;
  end

  assign stall_o        = stall;
  assign stall_reason_o = reason;
  assign issue_o        = issue;
  assign pending_o      = pending_q;
  assign outstanding_o  = out_q;
  assign stall_cnt_o    = cnt_q;
  assign err_o          = err_q;

endmodule
